rally_sequencer: RTL and testbench
==================================

// Module: rally_sequencer
// PURPOSE
//  Match-level sequencer for the ball-and-paddle game. It sequences the ball datapath
//  through serve / rally / point / game-over phases and decides when the ball launches
//  and in which direction. It turns miss and hit events from the ball engine into scores,
//  and detects the winner. It sits between the user controls and the ball/paddle
//  datapath inside game_controller.
// PARAMETERS
//  WIN_SCORE    15  points needed to win a match (1..2**SCORE_W-1)
//  SERVE_DELAY  60  frame_ticks waited before an auto serve
//  POINT_HOLD   30  frame_ticks the ball is frozen after a point
//  SCORE_W      6   score counter width
// PORTS
//  clk         in   1        system clock
//  rst         in   1        synchronous reset, active-high
//  frame_tick  in   1        one-cycle pulse once per video frame
//  mode        in   2        00 tennis, 01 soccer, 10 squash, 11 practice
//  serve_type  in   1        0 auto serve, 1 manual serve
//  serve       in   1        serve button, level; rising edge detected internally
//  miss_left   in   1        pulse: ball crossed the left boundary
//  miss_right  in   1        pulse: ball crossed the right boundary
//  hit_p1      in   1        pulse: ball struck paddle 1
//  hit_p2      in   1        pulse: ball struck paddle 2
//  ball_hold   out  1        1 = ball engine parks the ball at the serve position
//  ball_launch out  1        one-cycle pulse: start ball motion
//  serve_dir   out  1        0 = ball leaves toward right (P1 serves), 1 = toward left
//  p1_score    out  SCORE_W  player 1 score
//  p2_score    out  SCORE_W  player 2 score
//  game_over   out  1        match finished
//  winner      out  1        0 = P1, 1 = P2; valid while game_over=1
//  phase       out  3        state code: IDLE 0, SERVE 1, RALLY 2, POINT 3, OVER 4
// BEHAVIOUR
//  - Reset: state IDLE. Scores 0, ball_hold 1, ball_launch 0, serve_dir 0,
//    game_over 0, winner 0, frame counter 0, last_hitter P1. All outputs are registered.
//  - serve_rise = serve & ~serve_q. serve_q resets to 1, so a button held through reset
//    does not fire.
//  - IDLE: on serve_rise, latch mode and serve_type, clear scores, server=P1 -> SERVE.
//  - SERVE: ball_hold=1, serve_dir=server.
//    - Auto: count frame_ticks. On the tick that makes count==SERVE_DELAY, launch.
//    - Manual: launch on serve_rise.
//    - Launch = ball_launch high for exactly one cycle, ball_hold drops on that same
//      edge -> RALLY, counter cleared.
//  - RALLY: ball_hold=0. hit_p1/hit_p2 update last_hitter. On a miss -> POINT.
//    Scores update on the same edge; visible 1 cycle after the miss pulse.
//  - Point award:
//    - tennis/soccer: miss_left -> P2+1, server=P1; miss_right -> P1+1, server=P2.
//    - squash: either miss -> the player other than last_hitter +1; the loser serves.
//    - practice: no scoring, scores stay 0, server stays P1.
//  - Simultaneous miss_left and miss_right: miss_left wins, one point only.
//    Misses and hits outside RALLY are ignored.
//  - POINT: ball_hold=1. If the awarded score == WIN_SCORE -> OVER at once, with
//    game_over=1 and winner set. Otherwise wait POINT_HOLD frame_ticks -> SERVE.
//  - OVER: scores frozen, ball_hold=1. serve_rise re-latches mode, clears scores and
//    game_over -> SERVE.
//  - mode/serve_type changes during a match are ignored until the next latch.
//  - Scores never exceed WIN_SCORE; practice never reaches OVER.
//  - rst mid-rally takes priority over all events: full return to reset values on the
//    next edge.
// TESTING
//  - Reset with serve held high -> no launch. Release then press -> IDLE->SERVE,
//    phase=1, scores 0.
//  - Auto serve, SERVE_DELAY=3 -> ball_launch one cycle, on the cycle of the 3rd
//    frame_tick; ball_hold falls with it; serve_dir=0.
//  - Tennis, miss_left in RALLY -> p2_score=1 next cycle, phase=3. After POINT_HOLD
//    ticks -> SERVE, serve_dir=0.
//  - Same-cycle miss_left+miss_right -> only p2_score increments; a miss pulse during
//    SERVE -> no change.
//  - Squash: hit_p1 then miss_left -> p2_score+1. Run to WIN_SCORE=2 -> game_over=1,
//    winner=1; serve_rise restarts with 0-0.
//  - Practice, 20 misses -> scores stay 0, never OVER. rst asserted mid-RALLY ->
//    IDLE, all reset values.

Source files
------------

// File: rtl/rally_sequencer.sv
// rtl/rally_sequencer.sv - match-level serve/rally/point/game-over sequencer for the paddle game
//
// Drives the ball datapath through the serve, rally, point and game-over phases.
// It decides when the ball launches and in which direction, turns miss/hit events
// from the ball engine into scores, and detects the winner of the match.
//
// Ports
//   clk_i           system clock
//   rst_i           synchronous reset, active-high
//   frame_tick_i    one-cycle pulse once per video frame
//   mode_i          00 tennis, 01 soccer, 10 squash, 11 practice (latched at match start)
//   serve_type_i    0 auto serve, 1 manual serve (latched at match start)
//   serve_i         serve button level; rising edge detected internally
//   miss_left_i     pulse: ball crossed the left boundary
//   miss_right_i    pulse: ball crossed the right boundary
//   hit_p1_i        pulse: ball struck paddle 1
//   hit_p2_i        pulse: ball struck paddle 2
//   ball_hold_o     1 = ball parked at the serve position
//   ball_launch_o   one-cycle pulse starting ball motion
//   serve_dir_o     0 = ball leaves toward right (P1 serves), 1 = toward left
//   p1_score_o      player 1 score
//   p2_score_o      player 2 score
//   game_over_o     match finished
//   winner_o        0 = P1, 1 = P2; valid while game_over_o is high
//   phase_o         IDLE 0, SERVE 1, RALLY 2, POINT 3, OVER 4

module rally_sequencer #(
    parameter int unsigned WIN_SCORE   = 15,
    parameter int unsigned SERVE_DELAY = 60,
    parameter int unsigned POINT_HOLD  = 30,
    parameter int unsigned SCORE_W     = 6
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               frame_tick_i,
    input  logic [1:0]         mode_i,
    input  logic               serve_type_i,
    input  logic               serve_i,
    input  logic               miss_left_i,
    input  logic               miss_right_i,
    input  logic               hit_p1_i,
    input  logic               hit_p2_i,
    output logic               ball_hold_o,
    output logic               ball_launch_o,
    output logic               serve_dir_o,
    output logic [SCORE_W-1:0] p1_score_o,
    output logic [SCORE_W-1:0] p2_score_o,
    output logic               game_over_o,
    output logic               winner_o,
    output logic [2:0]         phase_o
);

    // One frame counter serves both the auto-serve delay and the point hold,
    // so it is sized for the longer of the two.
    localparam int unsigned MAX_WAIT = (SERVE_DELAY > POINT_HOLD) ? SERVE_DELAY : POINT_HOLD;
    localparam int unsigned CNT_W    = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    localparam logic [CNT_W-1:0]   SERVE_CNT = CNT_W'(SERVE_DELAY);
    localparam logic [CNT_W-1:0]   HOLD_CNT  = CNT_W'(POINT_HOLD);
    localparam logic [SCORE_W-1:0] WIN_CNT   = SCORE_W'(WIN_SCORE);

    localparam logic [1:0] MODE_SQUASH   = 2'b10;
    localparam logic [1:0] MODE_PRACTICE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_RALLY = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic               serve_q;
    logic [1:0]         mode_q, mode_d;
    logic               manual_q, manual_d;
    logic               server_q, server_d;
    logic               last_hitter_q, last_hitter_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] p1_q, p1_d;
    logic [SCORE_W-1:0] p2_q, p2_d;
    logic               hold_q, hold_d;
    logic               launch_q, launch_d;
    logic               dir_q, dir_d;
    logic               over_q, over_d;
    logic               winner_q, winner_d;

    logic               serve_rise;
    logic               launch_now;
    logic               award_p1;
    logic               award_p2;
    logic [CNT_W-1:0]   cnt_inc;
    logic [SCORE_W-1:0] p1_inc;
    logic [SCORE_W-1:0] p2_inc;

    always_comb begin
        serve_rise    = serve_i & ~serve_q;
        cnt_inc       = cnt_q + 1'b1;
        p1_inc        = p1_q + 1'b1;
        p2_inc        = p2_q + 1'b1;
        launch_now    = 1'b0;
        award_p1      = 1'b0;
        award_p2      = 1'b0;

        state_d       = state_q;
        mode_d        = mode_q;
        manual_d      = manual_q;
        server_d      = server_q;
        last_hitter_d = last_hitter_q;
        cnt_d         = cnt_q;
        p1_d          = p1_q;
        p2_d          = p2_q;
        hold_d        = hold_q;
        launch_d      = 1'b0;
        dir_d         = dir_q;
        over_d        = over_q;
        winner_d      = winner_q;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                // A new match always opens with P1 serving from 0-0.
                if (serve_rise) begin
                    mode_d   = mode_i;
                    manual_d = serve_type_i;
                    p1_d     = '0;
                    p2_d     = '0;
                    over_d   = 1'b0;
                    winner_d = 1'b0;
                    server_d = 1'b0;
                    dir_d    = 1'b0;
                    cnt_d    = '0;
                    hold_d   = 1'b1;
                    state_d  = ST_SERVE;
                end
            end

            ST_SERVE: begin
                if (manual_q) begin
                    launch_now = serve_rise;
                end else if (frame_tick_i) begin
                    cnt_d      = cnt_inc;
                    launch_now = (cnt_inc == SERVE_CNT);
                end
                if (launch_now) begin
                    launch_d = 1'b1;
                    hold_d   = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_RALLY;
                end
            end

            ST_RALLY: begin
                if (hit_p1_i) begin
                    last_hitter_d = 1'b0;
                end
                if (hit_p2_i) begin
                    last_hitter_d = 1'b1;
                end
                // miss_left takes precedence when both boundaries fire together,
                // so only one point is ever awarded per rally.
                if (miss_left_i | miss_right_i) begin
                    hold_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_POINT;
                    case (mode_q)
                        MODE_PRACTICE: begin
                            server_d = 1'b0;
                        end
                        MODE_SQUASH: begin
                            // The player who did not strike last takes the point;
                            // the last striker lost the rally and serves next.
                            award_p1 = last_hitter_q;
                            award_p2 = ~last_hitter_q;
                            server_d = last_hitter_q;
                        end
                        default: begin
                            award_p2 = miss_left_i;
                            award_p1 = ~miss_left_i;
                            server_d = ~miss_left_i;
                        end
                    endcase
                    if (award_p1) begin
                        p1_d = p1_inc;
                        if (p1_inc == WIN_CNT) begin
                            state_d  = ST_OVER;
                            over_d   = 1'b1;
                            winner_d = 1'b0;
                        end
                    end
                    if (award_p2) begin
                        p2_d = p2_inc;
                        if (p2_inc == WIN_CNT) begin
                            state_d  = ST_OVER;
                            over_d   = 1'b1;
                            winner_d = 1'b1;
                        end
                    end
                end
            end

            ST_POINT: begin
                if (frame_tick_i) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == HOLD_CNT) begin
                        cnt_d   = '0;
                        dir_d   = server_q;
                        state_d = ST_SERVE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                hold_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            // Reset to 1 so a button held through reset does not count as a press.
            serve_q       <= 1'b1;
            mode_q        <= 2'b00;
            manual_q      <= 1'b0;
            server_q      <= 1'b0;
            last_hitter_q <= 1'b0;
            cnt_q         <= '0;
            p1_q          <= '0;
            p2_q          <= '0;
            hold_q        <= 1'b1;
            launch_q      <= 1'b0;
            dir_q         <= 1'b0;
            over_q        <= 1'b0;
            winner_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            serve_q       <= serve_i;
            mode_q        <= mode_d;
            manual_q      <= manual_d;
            server_q      <= server_d;
            last_hitter_q <= last_hitter_d;
            cnt_q         <= cnt_d;
            p1_q          <= p1_d;
            p2_q          <= p2_d;
            hold_q        <= hold_d;
            launch_q      <= launch_d;
            dir_q         <= dir_d;
            over_q        <= over_d;
            winner_q      <= winner_d;
        end
    end

    assign ball_hold_o   = hold_q;
    assign ball_launch_o = launch_q;
    assign serve_dir_o   = dir_q;
    assign p1_score_o    = p1_q;
    assign p2_score_o    = p2_q;
    assign game_over_o   = over_q;
    assign winner_o      = winner_q;
    assign phase_o       = state_q;

endmodule

// File: tb/tb_rally_sequencer.sv
// tb/tb_rally_sequencer.sv - scoreboard bench for rally_sequencer with a rule-level reference model

module tb_rally_sequencer;

    localparam int WIN   = 2;
    localparam int SDLY  = 3;
    localparam int PHOLD = 4;
    localparam int SW    = 6;

    localparam int P_IDLE  = 0;
    localparam int P_SERVE = 1;
    localparam int P_RALLY = 2;
    localparam int P_POINT = 3;
    localparam int P_OVER  = 4;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          tick  = 1'b0;
    logic [1:0]    mode  = 2'b00;
    logic          stype = 1'b0;
    logic          serve = 1'b1;
    logic          ml    = 1'b0;
    logic          mr    = 1'b0;
    logic          h1    = 1'b0;
    logic          h2    = 1'b0;
    logic          hold, launch, sdir, over, win;
    logic [SW-1:0] p1, p2;
    logic [2:0]    phase;

    rally_sequencer #(
        .WIN_SCORE  (WIN),
        .SERVE_DELAY(SDLY),
        .POINT_HOLD (PHOLD),
        .SCORE_W    (SW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .frame_tick_i (tick),
        .mode_i       (mode),
        .serve_type_i (stype),
        .serve_i      (serve),
        .miss_left_i  (ml),
        .miss_right_i (mr),
        .hit_p1_i     (h1),
        .hit_p2_i     (h2),
        .ball_hold_o  (hold),
        .ball_launch_o(launch),
        .serve_dir_o  (sdir),
        .p1_score_o   (p1),
        .p2_score_o   (p2),
        .game_over_o  (over),
        .winner_o     (win),
        .phase_o      (phase)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [2:0]    phase;
        logic [SW-1:0] p1;
        logic [SW-1:0] p2;
        logic          hold;
        logic          launch;
        logic          dir;
        logic          over;
        logic          win;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t o;
    } ev_t;

    ev_t exp_q[$];

    // Reference model: the match as plain game rules.
    int   m_phase    = P_IDLE;
    int   m_sc[2]    = '{0, 0};
    bit   m_hold     = 1'b1;
    bit   m_launch   = 1'b0;
    bit   m_dir      = 1'b0;
    bit   m_over     = 1'b0;
    bit   m_win      = 1'b0;
    int   m_wait     = 0;
    int   m_last_hit = 0;
    int   m_server   = 0;
    int   m_mode     = 0;
    bit   m_manual   = 1'b0;
    bit   m_prev_btn = 1'b1;
    obs_t m_prev_obs;

    function automatic string fmt(obs_t o);
        return $sformatf("ph=%0d p1=%0d p2=%0d hold=%0b launch=%0b dir=%0b over=%0b win=%0b",
                         o.phase, o.p1, o.p2, o.hold, o.launch, o.dir, o.over, o.win);
    endfunction

    function obs_t model_obs();
        obs_t o;
        o.phase  = 3'(m_phase);
        o.p1     = SW'(m_sc[0]);
        o.p2     = SW'(m_sc[1]);
        o.hold   = m_hold;
        o.launch = m_launch;
        o.dir    = m_dir;
        o.over   = m_over;
        o.win    = m_win;
        return o;
    endfunction

    function obs_t dut_obs();
        obs_t o;
        o.phase  = phase;
        o.p1     = p1;
        o.p2     = p2;
        o.hold   = hold;
        o.launch = launch;
        o.dir    = sdir;
        o.over   = over;
        o.win    = win;
        return o;
    endfunction

    task automatic model_edge(input bit r, input bit tk, input bit [1:0] md, input bit st,
                              input bit sv, input bit l, input bit rt, input bit a, input bit b);
        bit rise;
        bit go;
        int taker;
        rise       = sv && !m_prev_btn;
        m_prev_btn = sv;
        if (r) begin
            m_phase = P_IDLE; m_sc[0] = 0; m_sc[1] = 0; m_hold = 1; m_launch = 0; m_dir = 0;
            m_over = 0; m_win = 0; m_wait = 0; m_last_hit = 0; m_server = 0; m_mode = 0;
            m_manual = 0; m_prev_btn = 1;
            return;
        end
        m_launch = 0;
        case (m_phase)
            P_IDLE, P_OVER: begin
                if (rise) begin
                    m_mode = md; m_manual = st; m_sc[0] = 0; m_sc[1] = 0; m_over = 0; m_win = 0;
                    m_server = 0; m_dir = 0; m_wait = 0; m_hold = 1; m_phase = P_SERVE;
                end
            end
            P_SERVE: begin
                go = 0;
                if (m_manual) go = rise;
                else if (tk) begin
                    m_wait++;
                    go = (m_wait == SDLY);
                end
                if (go) begin
                    m_launch = 1; m_hold = 0; m_wait = 0; m_phase = P_RALLY;
                end
            end
            P_RALLY: begin
                if (l || rt) begin
                    taker = -1;
                    if (m_mode == 3) m_server = 0;
                    else if (m_mode == 2) begin
                        taker    = 1 - m_last_hit;
                        m_server = m_last_hit;
                    end else begin
                        taker    = l ? 1 : 0;
                        m_server = l ? 0 : 1;
                    end
                    m_hold = 1;
                    m_wait = 0;
                    if (taker >= 0) m_sc[taker]++;
                    if (taker >= 0 && m_sc[taker] == WIN) begin
                        m_phase = P_OVER; m_over = 1; m_win = (taker == 1);
                    end else begin
                        m_phase = P_POINT;
                    end
                end else if (a) m_last_hit = 0;
                else if (b) m_last_hit = 1;
            end
            P_POINT: begin
                if (tk) begin
                    m_wait++;
                    if (m_wait == PHOLD) begin
                        m_wait = 0; m_phase = P_SERVE; m_dir = (m_server == 1);
                    end
                end
            end
            default: ;
        endcase
    endtask

    // One clock of stimulus; the model predicts the outputs after the coming edge
    // and any change in them is queued with the cycle it must appear on.
    task automatic step(input bit r, input bit tk, input bit [1:0] md, input bit st,
                        input bit sv, input bit l, input bit rt, input bit a, input bit b);
        obs_t o;
        ev_t  e;
        @(negedge clk);
        rst = r; tick = tk; mode = md; stype = st; serve = sv;
        ml = l; mr = rt; h1 = a; h2 = b;
        model_edge(r, tk, md, st, sv, l, rt, a, b);
        o = model_obs();
        if (o != m_prev_obs) begin
            e.cyc = cyc + 1;
            e.o   = o;
            exp_q.push_back(e);
            m_prev_obs = o;
        end
    endtask

    logic [1:0] cur_md = 2'b00;
    bit         cur_st = 1'b0;
    bit         cur_sv = 1'b1;

    task automatic drive(input bit tk, input bit l, input bit rt, input bit a, input bit b);
        step(1'b0, tk, cur_md, cur_st, cur_sv, l, rt, a, b);
    endtask

    task automatic press();
        cur_sv = 1'b0;
        drive(0, 0, 0, 0, 0);
        cur_sv = 1'b1;
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every change of the DUT outputs must match the next queued prediction.
    initial begin : monitor
        obs_t prev, cur;
        ev_t  e;
        prev = '{3'd0, {SW{1'b0}}, {SW{1'b0}}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        forever begin
            @(posedge clk);
            #1;
            cur = dut_obs();
            if (cur !== prev) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_change: cycle %0d got {%s}, expected no change", cyc, fmt(cur));
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.o !== cur) begin
                        n_bad++;
                        $display("FAIL output_event: got {%s} at cycle %0d, expected {%s} at cycle %0d",
                                 fmt(cur), cyc, fmt(e.o), e.cyc);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        n_bad++;
        $display("FAIL timeout: simulation exceeded its time budget");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : stimulus
        bit         r, tk, st, l, rt, a, b;
        bit [1:0]   md;
        m_prev_obs = model_obs();

        // Reset with the serve button held: no launch, still IDLE afterwards.
        for (int i = 0; i < 3; i++) step(1, 0, 2'b00, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        settle();
        chk("held_serve_phase", phase, 0);
        chk("held_serve_launch", launch, 0);
        chk("held_serve_hold", hold, 1);

        // Tennis, auto serve.
        cur_md = 2'b00; cur_st = 0;
        press();
        settle();
        chk("start_phase", phase, 1);
        chk("start_p1", p1, 0);
        chk("start_p2", p2, 0);
        chk("start_dir", sdir, 0);
        drive(1, 0, 0, 0, 0); drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0); drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        settle();
        chk("auto_launch", launch, 1);
        chk("auto_hold", hold, 0);
        chk("auto_phase", phase, 2);
        drive(0, 0, 0, 0, 0);
        settle();
        chk("launch_one_cycle", launch, 0);

        drive(0, 0, 0, 1, 0); drive(0, 0, 0, 0, 0); drive(0, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 0);
        settle();
        chk("tennis_miss_p2", p2, 1);
        chk("tennis_miss_p1", p1, 0);
        chk("tennis_miss_phase", phase, 3);
        for (int i = 0; i < PHOLD - 1; i++) begin
            drive(1, 0, 0, 0, 0);
            drive(0, 0, 0, 0, 0);
        end
        drive(1, 0, 0, 0, 0);
        settle();
        chk("hold_done_phase", phase, 1);
        chk("hold_done_dir", sdir, 0);

        // Misses during SERVE are ignored.
        drive(0, 1, 0, 0, 0); drive(0, 0, 1, 0, 0);
        settle();
        chk("serve_miss_p2", p2, 1);
        chk("serve_miss_phase", phase, 1);
        for (int i = 0; i < SDLY; i++) drive(1, 0, 0, 0, 0);
        settle();
        chk("relaunch_phase", phase, 2);

        // Simultaneous misses: only P2 scores, which here wins the match.
        drive(0, 1, 1, 0, 0);
        settle();
        chk("dual_miss_p2", p2, 2);
        chk("dual_miss_p1", p1, 0);
        chk("dual_miss_over", over, 1);
        chk("dual_miss_winner", win, 1);
        chk("dual_miss_phase", phase, 4);

        // Squash, manual serve.
        cur_md = 2'b10; cur_st = 1;
        press();
        settle();
        chk("squash_start_phase", phase, 1);
        chk("squash_start_p2", p2, 0);
        chk("squash_start_over", over, 0);
        press();
        settle();
        chk("manual_launch", launch, 1);
        drive(0, 0, 0, 1, 0);
        drive(0, 1, 0, 0, 0);
        settle();
        chk("squash_p2", p2, 1);
        chk("squash_p1", p1, 0);
        for (int i = 0; i < PHOLD; i++) drive(1, 0, 0, 0, 0);
        settle();
        chk("squash_server_dir", sdir, 0);
        press();
        drive(0, 0, 0, 1, 0);
        step(0, 0, 2'b00, cur_st, cur_sv, 0, 1, 0, 0);
        settle();
        chk("squash_win_p2", p2, 2);
        chk("squash_win_over", over, 1);
        chk("squash_win_winner", win, 1);

        // Practice: restart from OVER, many misses, never scores.
        cur_md = 2'b11;
        press();
        settle();
        chk("practice_start_p2", p2, 0);
        chk("practice_start_over", over, 0);
        for (int i = 0; i < 20; i++) begin
            press();
            drive(0, (i % 2) == 0, (i % 2) == 1, 0, 0);
            for (int k = 0; k < PHOLD; k++) drive(1, 0, 0, 0, 0);
        end
        settle();
        chk("practice_p1", p1, 0);
        chk("practice_p2", p2, 0);
        chk("practice_over", over, 0);
        chk("practice_phase", phase, 1);

        // Reset mid-rally wins over a concurrent miss.
        press();
        drive(0, 0, 0, 0, 0);
        step(1, 0, cur_md, cur_st, 1, 1, 0, 0, 0);
        settle();
        chk("rst_phase", phase, 0);
        chk("rst_hold", hold, 1);
        chk("rst_launch", launch, 0);
        chk("rst_scores", p1 + p2, 0);
        chk("rst_over", over, 0);
        chk("rst_dir", sdir, 0);

        // Randomized play against the model.
        for (int i = 0; i < 4000; i++) begin
            r  = ($urandom_range(0, 599) == 0);
            tk = ($urandom_range(0, 2) == 0);
            md = 2'($urandom_range(0, 3));
            st = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) cur_sv = ~cur_sv;
            l  = ($urandom_range(0, 9) == 0);
            rt = ($urandom_range(0, 9) == 0);
            a  = 0;
            b  = 0;
            if (!l && !rt) begin
                a = ($urandom_range(0, 5) == 0);
                b = !a && ($urandom_range(0, 5) == 0);
            end
            step(r, tk, md, st, cur_sv, l, rt, a, b);
        end

        for (int i = 0; i < 10; i++) step(0, 0, 2'b00, 0, cur_sv, 0, 0, 0, 0);
        settle();
        settle();
        chk("pending_events", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
